// File: rtl/stipple_pkg.sv
// Shared sizing helpers and the live-control bundle for the stipple stage.
// Sized for the largest supported pattern (PAT_LOG2 = 4).
package stipple_pkg;

   localparam int PAT_LOG2_MAX = 4;
   localparam int CFG_WORD_W   = 64;

   function automatic int pat_bits(input int plog2);
      return 1 << (2 * plog2);
   endfunction

   function automatic int pat_words(input int plog2);
      return (pat_bits(plog2) > CFG_WORD_W) ? pat_bits(plog2) / CFG_WORD_W : 1;
   endfunction

   function automatic int widx_w(input int plog2);
      return (2 * plog2 - 6 > 1) ? 2 * plog2 - 6 : 1;
   endfunction

   typedef struct packed {
      logic                    stipple_en;
      logic                    invert;
      logic [PAT_LOG2_MAX-1:0] off_x;
      logic [PAT_LOG2_MAX-1:0] off_y;
   } stipple_cfg_t;

endpackage

// File: rtl/stipple_pattern_buf.sv
// Double-buffered stipple pattern: 64-bit word writes into the shadow copy,
// frame-start commit into the active copy, combinational single-bit read.
module stipple_pattern_buf
   import stipple_pkg::*;
#(
   parameter  int PAT_LOG2  = 3,
   localparam int PAT_WORDS = pat_words(PAT_LOG2),
   localparam int WIDX_W    = widx_w(PAT_LOG2),
   localparam int IDX_W     = 2 * PAT_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr_en,
   input  logic [WIDX_W-1:0]     cfg_wr_idx,
   input  logic [CFG_WORD_W-1:0] cfg_wr_data,
   input  logic                  frame_start,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic                  rd_bit
);

   logic [PAT_WORDS-1:0][CFG_WORD_W-1:0] shadow_q;
   logic [PAT_WORDS-1:0][CFG_WORD_W-1:0] shadow_d;
   logic [PAT_WORDS-1:0][CFG_WORD_W-1:0] active_q;
   logic [PAT_WORDS*CFG_WORD_W-1:0]      active_flat;

   // With a single word the index is irrelevant and every write lands in word 0.
   generate
      for (genvar gi = 0; gi < PAT_WORDS; gi++) begin : g_word
         logic wr_hit;
         assign wr_hit       = cfg_wr_en && ((PAT_WORDS == 1) || (cfg_wr_idx == WIDX_W'(gi)));
         assign shadow_d[gi] = wr_hit ? cfg_wr_data : shadow_q[gi];
      end
   endgenerate

   // Commit copies shadow_d so a same-cycle write is included (write-through).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '1;
         active_q <= '1;
      end else begin
         shadow_q <= shadow_d;
         if (frame_start) begin
            active_q <= shadow_d;
         end
      end
   end

   assign active_flat = active_q;
   assign rd_bit      = active_flat[rd_idx];

endmodule

// File: rtl/stipple_stage.sv
// Stipple test stage: scrolled pattern lookup, discard, one-deep output register
// with valid/ready handshake. Define STIPPLE_STATS_EN for saturating discard statistics.
module stipple_stage
   import stipple_pkg::*;
#(
   parameter  int PAT_LOG2  = 3,
   parameter  int COORD_W   = 10,
   parameter  int PAYLOAD_W = 64,
   localparam int WIDX_W    = widx_w(PAT_LOG2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr_en,
   input  logic [WIDX_W-1:0]     cfg_wr_idx,
   input  logic [CFG_WORD_W-1:0] cfg_wr_data,
   input  logic                  frame_start,
   input  logic                  stipple_en,
   input  logic                  invert,
   input  logic [PAT_LOG2-1:0]   off_x,
   input  logic [PAT_LOG2-1:0]   off_y,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COORD_W-1:0]    in_x,
   input  logic [COORD_W-1:0]    in_y,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [COORD_W-1:0]    out_x,
   output logic [COORD_W-1:0]    out_y,
   output logic [PAYLOAD_W-1:0]  out_payload
`ifdef STIPPLE_STATS_EN
   ,
   input  logic                  stat_clear,
   output logic [31:0]           stat_tested,
   output logic [31:0]           stat_discards
`endif
);

   stipple_cfg_t          cfg;
   logic [PAT_LOG2-1:0]   px;
   logic [PAT_LOG2-1:0]   py;
   logic                  pat_bit;
   logic                  discard;
   logic                  accept;
   logic                  load;

   logic                  valid_q, valid_d;
   logic [COORD_W-1:0]    x_q, x_d;
   logic [COORD_W-1:0]    y_q, y_d;
   logic [PAYLOAD_W-1:0]  payload_q, payload_d;

   assign cfg.stipple_en = stipple_en;
   assign cfg.invert     = invert;
   assign cfg.off_x      = PAT_LOG2_MAX'(off_x);
   assign cfg.off_y      = PAT_LOG2_MAX'(off_y);

   // Scroll additions wrap inside the pattern side; the carry is dropped.
   assign px = in_x[PAT_LOG2-1:0] + cfg.off_x[PAT_LOG2-1:0];
   assign py = in_y[PAT_LOG2-1:0] + cfg.off_y[PAT_LOG2-1:0];

   stipple_pattern_buf #(
      .PAT_LOG2 (PAT_LOG2)
   ) u_pattern_buf (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr_en   (cfg_wr_en),
      .cfg_wr_idx  (cfg_wr_idx),
      .cfg_wr_data (cfg_wr_data),
      .frame_start (frame_start),
      .rd_idx      ({py, px}),
      .rd_bit      (pat_bit)
   );

   assign discard  = cfg.stipple_en && (pat_bit == cfg.invert);
   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign load     = accept & ~discard;

   always_comb begin
      valid_d   = valid_q;
      x_d       = x_q;
      y_d       = y_q;
      payload_d = payload_q;
      if (load) begin
         valid_d   = 1'b1;
         x_d       = in_x;
         y_d       = in_y;
         payload_d = in_payload;
      end else if (out_ready) begin
         valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         x_q       <= x_d;
         y_q       <= y_d;
         payload_q <= payload_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_x       = x_q;
   assign out_y       = y_q;
   assign out_payload = payload_q;

`ifdef STIPPLE_STATS_EN
   logic [31:0] tested_q, tested_d;
   logic [31:0] disc_q, disc_d;

   // Clear wins over a same-cycle increment; both counters saturate.
   always_comb begin
      tested_d = tested_q;
      disc_d   = disc_q;
      if (stat_clear) begin
         tested_d = '0;
         disc_d   = '0;
      end else begin
         if (accept && cfg.stipple_en && (tested_q != '1)) begin
            tested_d = tested_q + 32'd1;
         end
         if (accept && discard && (disc_q != '1)) begin
            disc_d = disc_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tested_q <= '0;
         disc_q   <= '0;
      end else begin
         tested_q <= tested_d;
         disc_q   <= disc_d;
      end
   end

   assign stat_tested   = tested_q;
   assign stat_discards = disc_q;
`endif

endmodule

// File: tb/tb_stipple_stage.sv
// Directed bench for stipple_stage: an 8x8 instance and a 16x16 instance
// sharing fragment and control inputs, checked with immediate assertions.
module tb_stipple_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr8, wr16;
   logic [1:0]  widx;
   logic [63:0] wdata;
   logic        fs;
   logic        en, inv;
   logic [3:0]  offx, offy;
   logic        in_valid;
   logic [9:0]  in_x, in_y;
   logic [63:0] pl;
   logic        out_ready;

   logic        in_ready8, out_valid8;
   logic [9:0]  out_x8, out_y8;
   logic [63:0] out_pl8;
   logic        in_ready16, out_valid16;
   logic [9:0]  out_x16, out_y16;
   logic [63:0] out_pl16;

`ifdef STIPPLE_STATS_EN
   logic        stat_clr;
   logic [31:0] tested8, disc8, tested16, disc16;
`endif

   int checks = 0;
   int errors = 0;
   int npass;

   always #5 clk = ~clk;

   stipple_stage #(.PAT_LOG2(3), .COORD_W(10), .PAYLOAD_W(64)) u_dut8 (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr_en   (wr8),
      .cfg_wr_idx  (widx[0]),
      .cfg_wr_data (wdata),
      .frame_start (fs),
      .stipple_en  (en),
      .invert      (inv),
      .off_x       (offx[2:0]),
      .off_y       (offy[2:0]),
      .in_valid    (in_valid),
      .in_ready    (in_ready8),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_payload  (pl),
      .out_valid   (out_valid8),
      .out_ready   (out_ready),
      .out_x       (out_x8),
      .out_y       (out_y8),
      .out_payload (out_pl8)
`ifdef STIPPLE_STATS_EN
      ,
      .stat_clear    (stat_clr),
      .stat_tested   (tested8),
      .stat_discards (disc8)
`endif
   );

   stipple_stage #(.PAT_LOG2(4), .COORD_W(10), .PAYLOAD_W(64)) u_dut16 (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr_en   (wr16),
      .cfg_wr_idx  (widx),
      .cfg_wr_data (wdata),
      .frame_start (fs),
      .stipple_en  (en),
      .invert      (inv),
      .off_x       (offx),
      .off_y       (offy),
      .in_valid    (in_valid),
      .in_ready    (in_ready16),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_payload  (pl),
      .out_valid   (out_valid16),
      .out_ready   (out_ready),
      .out_x       (out_x16),
      .out_y       (out_y16),
      .out_payload (out_pl16)
`ifdef STIPPLE_STATS_EN
      ,
      .stat_clear    (stat_clr),
      .stat_tested   (tested16),
      .stat_discards (disc16)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frag(input int x, input int y, input logic [63:0] p);
      in_x     = 10'(x);
      in_y     = 10'(y);
      pl       = p;
      in_valid = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr8 = 1'b0; wr16 = 1'b0; widx = '0; wdata = '0; fs = 1'b0;
      en = 1'b0; inv = 1'b0; offx = '0; offy = '0; in_valid = 1'b0;
      in_x = '0; in_y = '0; pl = '0; out_ready = 1'b1;
`ifdef STIPPLE_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (2) step();
      chk("rst_out_valid", out_valid8, 1'b0);
      chk("rst_in_ready", in_ready8, 1'b1);
      chk("rst_out_x", out_x8, 10'd0);
      chk("rst_out_payload", out_pl8, 64'd0);
      chk("rst_out_valid16", out_valid16, 1'b0);
      rst = 1'b0;
      step();
      chk("idle_out_valid", out_valid8, 1'b0);
      chk("idle_in_ready", in_ready8, 1'b1);

      // Default all-ones pattern passes everything, one cycle latency.
      en = 1'b1;
      frag(0, 0, 64'hDEAD_BEEF_0000_0001);
      chk("lat_pre_valid", out_valid8, 1'b0);
      step(); in_valid = 1'b0;
      chk("def00_valid", out_valid8, 1'b1);
      chk("def00_payload", out_pl8, 64'hDEAD_BEEF_0000_0001);
      step();
      chk("def00_drain", out_valid8, 1'b0);
      frag(7, 7, 64'hDEAD_BEEF_0000_0077);
      step(); in_valid = 1'b0;
      chk("def77_valid", out_valid8, 1'b1);
      chk("def77_x", out_x8, 10'd7);
      chk("def77_y", out_y8, 10'd7);
      chk("def77_payload", out_pl8, 64'hDEAD_BEEF_0000_0077);
      step();

      // Shadow write must not affect the active pattern until commit.
      wr8 = 1'b1; widx = 2'd0; wdata = 64'h0000_0000_0000_00FF;
      step(); wr8 = 1'b0;
      frag(3, 3, 64'h33);
      step(); in_valid = 1'b0;
      chk("precommit_pass", out_valid8, 1'b1);
      fs = 1'b1;
`ifdef STIPPLE_STATS_EN
      stat_clr = 1'b1;
`endif
      step(); fs = 1'b0;
`ifdef STIPPLE_STATS_EN
      stat_clr = 1'b0;
`endif

      // Row 0 only survives.
      npass = 0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            frag(x, y, 64'((y << 8) | x));
            step();
            chk($sformatf("stream_%0d_%0d_valid", x, y), out_valid8, (y == 0));
            if (out_valid8 === 1'b1) npass++;
            if (y == 0) chk($sformatf("stream_%0d_x", x), out_x8, 10'(x));
         end
      end
      in_valid = 1'b0;
      chk("stream_npass", 64'(npass), 64'd8);
`ifdef STIPPLE_STATS_EN
      chk("stat_tested64", tested8, 32'd64);
      chk("stat_disc56", disc8, 32'd56);
      frag(0, 1, 64'h1);
      stat_clr = 1'b1;
      step(); in_valid = 1'b0; stat_clr = 1'b0;
      chk("stat_clr_tested", tested8, 32'd0);
      chk("stat_clr_disc", disc8, 32'd0);
`endif
      step();

      // Y scroll: (3,1) with off_y=7 reads row 0.
      offy = 4'd7;
      frag(3, 1, 64'h31);
      step(); in_valid = 1'b0; offy = 4'd0;
      chk("offy_valid", out_valid8, 1'b1);
      chk("offy_y", out_y8, 10'd1);
      inv = 1'b1;
      frag(3, 0, 64'h30);
      step(); in_valid = 1'b0;
      chk("inv_discard_valid", out_valid8, 1'b0);
      chk("inv_discard_hold_y", out_y8, 10'd1);
      frag(4, 5, 64'h45);
      step(); in_valid = 1'b0;
      chk("inv_pass_valid", out_valid8, 1'b1);
      chk("inv_pass_y", out_y8, 10'd5);
      en = 1'b0;
      frag(3, 0, 64'h30);
      step(); in_valid = 1'b0;
      chk("en0_pass_valid", out_valid8, 1'b1);
      chk("en0_pass_y", out_y8, 10'd0);
      en = 1'b1; inv = 1'b0;
      step();

      // 16x16: only (15,15) set, in word 3 bit 63.
      wr16 = 1'b1;
      for (int w = 0; w < 4; w++) begin
         widx  = 2'(w);
         wdata = (w == 3) ? 64'h8000_0000_0000_0000 : 64'h0;
         step();
      end
      wr16 = 1'b0;
      frag(0, 0, 64'h0);
      step(); in_valid = 1'b0;
      chk("p16_precommit", out_valid16, 1'b1);
      fs = 1'b1;
      step(); fs = 1'b0;
      frag(15, 15, 64'hFF);
      step();
      chk("p16_ff_valid", out_valid16, 1'b1);
      chk("p16_ff_x", out_x16, 10'd15);
      frag(14, 15, 64'hEF);
      step();
      chk("p16_ef_discard", out_valid16, 1'b0);
      frag(0, 0, 64'h0);
      step();
      chk("p16_00_discard", out_valid16, 1'b0);
      offx = 4'd1;
      frag(14, 15, 64'hEF);
      step(); offx = 4'd0;
      chk("p16_offx_valid", out_valid16, 1'b1);
      chk("p16_offx_x", out_x16, 10'd14);

      // Same-cycle write + commit + fragment: fragment sees old pattern.
      wr16 = 1'b1; widx = 2'd3; wdata = 64'h1; fs = 1'b1;
      frag(15, 15, 64'hFF);
      step(); wr16 = 1'b0; fs = 1'b0;
      chk("p16_samecyc_old", out_valid16, 1'b1);
      frag(15, 15, 64'hFF);
      step();
      chk("p16_new_discard", out_valid16, 1'b0);
      frag(0, 12, 64'hC0);
      step(); in_valid = 1'b0;
      chk("p16_writethru_valid", out_valid16, 1'b1);
      chk("p16_writethru_y", out_y16, 10'd12);
      step();

      // Backpressure on the 8x8 instance.
      out_ready = 1'b0;
      frag(1, 0, 64'hAAAA_0001);
      chk("bp_ready_first", in_ready8, 1'b1);
      step();
      chk("bp_first_valid", out_valid8, 1'b1);
      frag(2, 0, 64'hAAAA_0002);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_ready_low_%0d", i), in_ready8, 1'b0);
         step();
         chk($sformatf("bp_hold_payload_%0d", i), out_pl8, 64'hAAAA_0001);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_release", in_ready8, 1'b1);
      step(); in_valid = 1'b0;
      chk("bp_second_valid", out_valid8, 1'b1);
      chk("bp_second_payload", out_pl8, 64'hAAAA_0002);
      step();
      chk("bp_no_dup", out_valid8, 1'b0);

      // Async reset drops a held fragment and restores the all-ones pattern.
      out_ready = 1'b0;
      frag(5, 0, 64'hBBBB_0005);
      step(); in_valid = 1'b0;
      chk("mid_rst_held", out_valid8, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid8, 1'b0);
      chk("mid_rst_ready", in_ready8, 1'b1);
      chk("mid_rst_payload", out_pl8, 64'd0);
      step(); rst = 1'b0; out_ready = 1'b1;
      frag(0, 1, 64'h10);
      step(); in_valid = 1'b0;
      chk("post_rst_pattern", out_valid8, 1'b1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
